// File: rtl/nn_addr_pkg.sv
// Packed BRAM layout for the FC inference path: per-layer sizes, region bases and FSM states.
// All bases are elaboration-time constants; layer k+1 weights start right after layer k's bias word.
package nn_addr_pkg;

    localparam int ADDR_W     = 10;
    localparam int NUM_LAYERS = 3;
    localparam int LSEL_W     = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    localparam int                IN_COUNT [NUM_LAYERS] = '{784, 20, 20};
    localparam logic [ADDR_W-1:0] X_BASE   [NUM_LAYERS] = '{10'h000, 10'h000, 10'h000};
    localparam logic [ADDR_W-1:0] W_BASE0               = 10'h000;

    function automatic int w_base(input int k);
        int b;
        b = int'(W_BASE0);
        for (int j = 0; j < k; j++) b += IN_COUNT[j] + 1;
        return b;
    endfunction

    function automatic int b_base(input int k);
        return w_base(k) + IN_COUNT[k];
    endfunction

    function automatic int max_in_count();
        int m;
        m = 1;
        for (int j = 0; j < NUM_LAYERS; j++) if (IN_COUNT[j] > m) m = IN_COUNT[j];
        return m;
    endfunction

    localparam int CNT_W = $clog2(max_in_count()) + 1;

    // Legacy fixed addresses, kept for older callers; derived so they can never drift.
    localparam logic [ADDR_W-1:0] WEIGHT_0 = ADDR_W'(w_base(0));
    localparam logic [ADDR_W-1:0] BIAS_0   = ADDR_W'(b_base(0));
    localparam logic [ADDR_W-1:0] WEIGHT_1 = ADDR_W'(w_base(1));
    localparam logic [ADDR_W-1:0] BIAS_1   = ADDR_W'(b_base(1));
    localparam logic [ADDR_W-1:0] WEIGHT_2 = ADDR_W'(w_base(2));
    localparam logic [ADDR_W-1:0] BIAS_2   = ADDR_W'(b_base(2));

    typedef enum logic [2:0] {
        S_IDLE,
        S_WEIGHT,
        S_BIAS,
        S_GAP,
        S_FIN
    } seq_state_t;

endpackage

// File: rtl/nn_beat_counter.sv
// Loadable up-counter with terminal-count flag; load wins over enable.
// Latency: count visible the cycle after en/load. Backpressure: caller gates en with the transfer.
module nn_beat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] term_val,
    output logic [W-1:0] cnt,
    output logic         tc
);

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == term_val);

endmodule

// File: rtl/nn_layer_addr_seq.sv
// Weight/bias/input BRAM address sequencer for FC layers, optional chaining with drain gap.
// Latency: first beat 1 cycle after Start. Backpressure: beat held stable until Out_ready.
module nn_layer_addr_seq
    import nn_addr_pkg::*;
#(
    parameter int GAP_CYCLES = 4
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic [LSEL_W-1:0] Layer_sel,
    input  logic              Chain,
    input  logic              Out_ready,
    output logic              Out_valid,
    output logic [ADDR_W-1:0] W_addr,
    output logic [ADDR_W-1:0] X_addr,
    output logic              Is_bias,
    output logic              Last,
    output logic [LSEL_W-1:0] Layer_idx,
    output logic              Busy,
    output logic              Done,
    output logic              Err
);

    localparam int TAB_N = 1 << LSEL_W;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    if (b_base(NUM_LAYERS - 1) >= (1 << ADDR_W)) begin : g_addr_chk
        $error("final bias address does not fit in ADDR_W");
    end

    // Constant per-layer tables; unused slots past NUM_LAYERS read as zero.
    logic [ADDR_W-1:0] wb_tab   [TAB_N];
    logic [ADDR_W-1:0] bb_tab   [TAB_N];
    logic [ADDR_W-1:0] xb_tab   [TAB_N];
    logic [CNT_W-1:0]  term_tab [TAB_N];

    for (genvar g = 0; g < TAB_N; g++) begin : g_tab
        if (g < NUM_LAYERS) begin : g_on
            if (IN_COUNT[g] == 0) begin : g_zero_chk
                $error("IN_COUNT of a layer must be non-zero");
            end
            assign wb_tab[g]   = ADDR_W'(w_base(g));
            assign bb_tab[g]   = ADDR_W'(b_base(g));
            assign xb_tab[g]   = X_BASE[g];
            assign term_tab[g] = CNT_W'(IN_COUNT[g] - 1);
        end else begin : g_off
            assign wb_tab[g]   = '0;
            assign bb_tab[g]   = '0;
            assign xb_tab[g]   = '0;
            assign term_tab[g] = '0;
        end
    end

    seq_state_t        state_q, state_d;
    logic [LSEL_W-1:0] layer_q;
    logic              chain_q;
    logic              err_q;
    logic [GAP_W-1:0]  gap_q;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_tc;
    logic              sel_ok, accept, xfer, in_weight, in_bias, is_last, gap_done;

    assign sel_ok    = int'(Layer_sel) < NUM_LAYERS;
    assign accept    = (state_q == S_IDLE) && Start && sel_ok;
    assign in_weight = (state_q == S_WEIGHT);
    assign in_bias   = (state_q == S_BIAS);
    assign xfer      = (in_weight || in_bias) && Out_ready;
    assign is_last   = in_bias && (!chain_q || (layer_q == LSEL_W'(NUM_LAYERS - 1)));
    assign gap_done  = (int'(gap_q) == GAP_CYCLES - 1);

    nn_beat_counter #(.W(CNT_W)) u_cnt (
        .clk      (Clk),
        .rst_n    (Reset_n),
        .load     (accept || (in_bias && xfer)),
        .load_val ('0),
        .en       (in_weight && xfer && !cnt_tc),
        .term_val (term_tab[layer_q]),
        .cnt      (cnt),
        .tc       (cnt_tc)
    );

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            layer_q <= '0;
            chain_q <= 1'b0;
            err_q   <= 1'b0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= (state_q == S_IDLE) && Start && !sel_ok;
            gap_q   <= (state_q == S_GAP) ? gap_q + 1'b1 : '0;
            if (accept) begin
                layer_q <= Layer_sel;
                chain_q <= Chain;
            end else if (in_bias && xfer && !is_last) begin
                layer_q <= layer_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (accept) state_d = S_WEIGHT;
            S_WEIGHT: if (xfer && cnt_tc) state_d = S_BIAS;
            S_BIAS: begin
                if (xfer) begin
                    if (is_last)              state_d = S_FIN;
                    else if (GAP_CYCLES == 0) state_d = S_WEIGHT;
                    else                      state_d = S_GAP;
                end
            end
            S_GAP:    if (gap_done) state_d = S_WEIGHT;
            S_FIN:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign Out_valid = in_weight || in_bias;
    assign Is_bias   = in_bias;
    assign Last      = is_last;
    assign W_addr    = in_weight ? wb_tab[layer_q] + ADDR_W'(cnt) : (in_bias ? bb_tab[layer_q] : '0);
    assign X_addr    = in_weight ? xb_tab[layer_q] + ADDR_W'(cnt) : '0;
    assign Layer_idx = layer_q;
    assign Busy      = (state_q != S_IDLE) && (state_q != S_FIN);
    assign Done      = (state_q == S_FIN);
    assign Err       = err_q;

endmodule

// File: tb/tb_nn_layer_addr_seq.sv
// Drives two sequencer builds (default gap and zero gap) and checks every beat against a layout model.
module tb_nn_layer_addr_seq;

    localparam int NL = 3;
    int in_cnt [NL] = '{784, 20, 20};
    int xb     [NL] = '{0, 0, 0};

    logic       Clk = 1'b0;
    logic       Reset_n, Start, Chain, Out_ready;
    logic [1:0] Layer_sel;

    logic       ov, ib, la, bu, dn, er;
    logic [9:0] wa, xa;
    logic [1:0] li;
    logic       d0_ov, d0_ib, d0_la, d0_bu, d0_dn, d0_er;
    logic [9:0] d0_wa, d0_xa;
    logic [1:0] d0_li;

    int total = 0;
    int bad   = 0;
    bit which = 1'b0;

    logic [23:0] obs_beat;
    logic        obs_v, obs_done, obs_busy;

    always #5 Clk = ~Clk;

    nn_layer_addr_seq #(.GAP_CYCLES(4)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Layer_sel(Layer_sel), .Chain(Chain),
        .Out_ready(Out_ready), .Out_valid(ov), .W_addr(wa), .X_addr(xa), .Is_bias(ib),
        .Last(la), .Layer_idx(li), .Busy(bu), .Done(dn), .Err(er)
    );

    nn_layer_addr_seq #(.GAP_CYCLES(0)) dut0 (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Layer_sel(Layer_sel), .Chain(Chain),
        .Out_ready(Out_ready), .Out_valid(d0_ov), .W_addr(d0_wa), .X_addr(d0_xa), .Is_bias(d0_ib),
        .Last(d0_la), .Layer_idx(d0_li), .Busy(d0_bu), .Done(d0_dn), .Err(d0_er)
    );

    always_comb begin
        if (which) begin
            obs_beat = {d0_wa, d0_xa, d0_ib, d0_la, d0_li};
            obs_v    = d0_ov;
            obs_done = d0_dn;
            obs_busy = d0_bu;
        end else begin
            obs_beat = {wa, xa, ib, la, li};
            obs_v    = ov;
            obs_done = dn;
            obs_busy = bu;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller is positioned at a negedge; returns at a negedge with both builds idle.
    task automatic run(input int sel, input bit ch, input bit rnd, input int gap_exp, input int mid_start);
        logic [23:0] exp_q[$];
        logic [24:0] prev;
        int          last_k, wb, n, idx, gap_run, cyc;
        bit          prev_stall, prev_bias, xfer;
        last_k = ch ? NL - 1 : sel;
        for (int k = sel; k <= last_k; k++) begin
            wb = 0;
            for (int j = 0; j < k; j++) wb += in_cnt[j] + 1;
            for (int i = 0; i < in_cnt[k]; i++)
                exp_q.push_back({10'(wb + i), 10'(xb[k] + i), 1'b0, 1'b0, 2'(k)});
            exp_q.push_back({10'(wb + in_cnt[k]), 10'h000, 1'b1, (k == last_k), 2'(k)});
        end
        n = exp_q.size();
        idx = 0; gap_run = 0; cyc = 0;
        prev_stall = 1'b0; prev_bias = 1'b0; prev = '0;
        Start = 1'b1; Layer_sel = 2'(sel); Chain = ch; Out_ready = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        chk("first_valid", {31'd0, obs_v}, 32'd1);
        chk("busy_run", {31'd0, obs_busy}, 32'd1);
        while (idx < n && cyc < 4000) begin
            if (prev_stall) chk("stall_hold", {7'd0, obs_v, obs_beat}, {7'd0, prev});
            if (cyc == mid_start) begin
                Start = 1'b1;
                Layer_sel = 2'd0;
            end else begin
                Start = 1'b0;
            end
            Out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            xfer = obs_v && Out_ready;
            if (obs_v && !prev_stall) begin
                if (idx > 0) chk("gap_len", gap_run, prev_bias ? gap_exp : 0);
                gap_run = 0;
            end
            if (!obs_v) gap_run++;
            if (xfer) begin
                chk("beat", {8'd0, obs_beat}, {8'd0, exp_q[idx]});
                prev_bias = obs_beat[3];
                idx++;
            end
            prev_stall = obs_v && !Out_ready;
            prev = {obs_v, obs_beat};
            cyc++;
            @(negedge Clk);
        end
        chk("beat_count", idx, n);
        chk("done_pulse", {29'd0, obs_done, obs_busy, obs_v}, 32'b100);
        @(negedge Clk);
        chk("done_clear", {30'd0, obs_done, obs_busy}, 32'd0);
        Start = 1'b0;
        Out_ready = 1'b1;
        repeat (12) @(negedge Clk);
    endtask

    initial begin
        int cyc;
        Reset_n = 1'b0; Start = 1'b0; Chain = 1'b0; Out_ready = 1'b0; Layer_sel = 2'd0;
        repeat (3) @(negedge Clk);
        chk("reset_outs", {4'd0, ov, wa, xa, ib, la, li, bu, dn, er}, 32'd0);
        chk("reset_outs_g0", {4'd0, d0_ov, d0_wa, d0_xa, d0_ib, d0_la, d0_li, d0_bu, d0_dn, d0_er}, 32'd0);
        Reset_n = 1'b1;
        @(negedge Clk);

        run(1, 1'b0, 1'b0, 4, -1);
        run(0, 1'b1, 1'b0, 4, -1);
        run(2, 1'b0, 1'b1, 4, 5);

        Start = 1'b1; Layer_sel = 2'd3;
        @(negedge Clk);
        Start = 1'b0;
        chk("err_pulse", {29'd0, er, bu, ov}, 32'b100);
        @(negedge Clk);
        chk("err_clear", {29'd0, er, bu, ov}, 32'd0);

        Start = 1'b1; Layer_sel = 2'd1; Chain = 1'b0; Out_ready = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        cyc = 0;
        while (wa !== 10'h31B && cyc < 200) begin
            @(negedge Clk);
            cyc++;
        end
        chk("reach_i10", {22'd0, wa}, 32'h31B);
        Reset_n = 1'b0;
        @(negedge Clk);
        chk("midrun_reset", {4'd0, ov, wa, xa, ib, la, li, bu, dn, er}, 32'd0);
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("no_done_after_reset", {30'd0, dn, bu}, 32'd0);
        run(1, 1'b0, 1'b0, 4, -1);

        which = 1'b1;
        run(1, 1'b1, 1'b0, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
